// File: rtl/usb_buffer_pkg.sv
// Shared constants and enums for the endpoint data buffer arbiter slice.
package usb_buffer_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);

  typedef enum logic {
    REQ_AHB,
    REQ_USB
  } requester_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_STORE,
    ACC_GET
  } access_t;

endpackage

// File: rtl/buffer_pointer_tracker.sv
// Circular write/read pointers and occupancy count for the endpoint buffer.
// Occupancy is one bit wider than the pointers so full and empty are distinct.
module buffer_pointer_tracker
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          store,
  input  logic          get,
  input  logic          clear,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW:0]   occupancy,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (get)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, get})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign full  = (occupancy == (AW + 1)'(DEPTH));
  assign empty = (occupancy == '0);

endmodule

// File: rtl/buffer_access_arbiter.sv
// Grants one access per cycle to the shared single-port endpoint buffer.
// Optional macro USB_PRIORITY_EN: USB always wins a conflict instead of round-robin.
module buffer_access_arbiter
  import usb_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = BUF_AW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          d_mode,
  input  logic          clear,
  input  logic          ahb_store_req,
  input  logic          ahb_get_req,
  input  logic [7:0]    ahb_wdata,
  input  logic          usb_store_req,
  input  logic          usb_get_req,
  input  logic [7:0]    usb_wdata,
  output logic          ahb_grant,
  output logic          usb_grant,
  output logic          ahb_rdata_valid,
  output logic          usb_rdata_valid,
  output logic [7:0]    rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [AW:0]   buffer_occupancy,
  output logic          overflow_err,
  output logic          underflow_err
);

  // Handshake: a requester holds its req level until it sees grant in the
  // same cycle; grant is the only acknowledgement. Read data follows a get
  // grant by one cycle, flagged by a one-cycle rdata_valid pulse.

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  access_t       ahb_acc, usb_acc, win_acc;
  logic          ahb_elig, usb_elig, usb_wins, active;
  logic          do_store, do_get;
  logic          store_pending, get_pending;
  logic          ahb_pend, usb_pend;

  // Direction of each side is fixed by d_mode; the other request is ignored.
  always_comb begin
    ahb_acc = ACC_NONE;
    usb_acc = ACC_NONE;
    if (!d_mode && ahb_store_req)     ahb_acc = ACC_STORE;
    else if (d_mode && ahb_get_req)   ahb_acc = ACC_GET;
    if (d_mode && usb_store_req)      usb_acc = ACC_STORE;
    else if (!d_mode && usb_get_req)  usb_acc = ACC_GET;
  end

  assign ahb_elig = ((ahb_acc == ACC_STORE) && !full) || ((ahb_acc == ACC_GET) && !empty);
  assign usb_elig = ((usb_acc == ACC_STORE) && !full) || ((usb_acc == ACC_GET) && !empty);

`ifdef USB_PRIORITY_EN
  assign usb_wins = usb_elig;
`else
  requester_t last_winner;

  assign usb_wins = usb_elig && (!ahb_elig || (last_winner == REQ_AHB));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       last_winner <= REQ_AHB;
    else if (clear)                   last_winner <= REQ_AHB;
    else if (usb_grant)               last_winner <= REQ_USB;
    else if (ahb_grant)               last_winner <= REQ_AHB;
  end
`endif

  // Reset and clear both force every combinational output quiet at once.
  assign active    = n_rst && !clear;
  assign usb_grant = active && usb_wins;
  assign ahb_grant = active && ahb_elig && !usb_wins;

  always_comb begin
    win_acc = ACC_NONE;
    if (usb_grant)      win_acc = usb_acc;
    else if (ahb_grant) win_acc = ahb_acc;
  end

  assign do_store  = (win_acc == ACC_STORE);
  assign do_get    = (win_acc == ACC_GET);
  assign mem_we    = do_store;
  assign mem_addr  = do_get ? rd_ptr : wr_ptr;
  assign mem_wdata = do_store ? (usb_grant ? usb_wdata : ahb_wdata) : 8'h00;

  assign store_pending = (ahb_acc == ACC_STORE) || (usb_acc == ACC_STORE);
  assign get_pending   = (ahb_acc == ACC_GET) || (usb_acc == ACC_GET);
  assign overflow_err  = active && store_pending && full;
  assign underflow_err = active && get_pending && empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ahb_pend <= 1'b0;
      usb_pend <= 1'b0;
    end else begin
      ahb_pend <= ahb_grant && do_get;
      usb_pend <= usb_grant && do_get;
    end
  end

  // A clear in the data-return cycle discards the byte already in flight.
  assign ahb_rdata_valid = ahb_pend && !clear;
  assign usb_rdata_valid = usb_pend && !clear;
  assign rdata           = mem_rdata;

  buffer_pointer_tracker #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_tracker (
    .clk      (clk),
    .n_rst    (n_rst),
    .store    (do_store),
    .get      (do_get),
    .clear    (clear),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .occupancy(buffer_occupancy),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Bench for buffer_access_arbiter: FIFO-queue reference model, behavioural RAM,
// directed scenarios from the test plan plus a randomized run.
module tb_buffer_access_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_mode, clear;
  logic       ahb_store_req, ahb_get_req, usb_store_req, usb_get_req;
  logic [7:0] ahb_wdata, usb_wdata;
  logic       ahb_grant, usb_grant, ahb_rdata_valid, usb_rdata_valid;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [6:0] buffer_occupancy;
  logic       overflow_err, underflow_err;

  int n_cmp = 0;
  int n_fail = 0;

  buffer_access_arbiter dut (
    .clk(clk), .n_rst(n_rst), .d_mode(d_mode), .clear(clear),
    .ahb_store_req(ahb_store_req), .ahb_get_req(ahb_get_req), .ahb_wdata(ahb_wdata),
    .usb_store_req(usb_store_req), .usb_get_req(usb_get_req), .usb_wdata(usb_wdata),
    .ahb_grant(ahb_grant), .usb_grant(usb_grant),
    .ahb_rdata_valid(ahb_rdata_valid), .usb_rdata_valid(usb_rdata_valid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .buffer_occupancy(buffer_occupancy),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural synchronous single-port RAM
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // reference model: bytes held in FIFO order plus write/read position counts
  logic [7:0] exp_q[$];
  int         wcnt, rcnt;
  bit         last_usb;
  int         pend;
  logic [7:0] pend_data;

  // observation vector layout
  // [35]ag [34]ug [33]we [32:27]addr [26:19]wdata [18]ovf [17]unf [16]av [15]uv [14:7]rdata [6:0]occ
  task automatic model_reset();
    exp_q.delete();
    wcnt = 0; rcnt = 0; last_usb = 1'b0; pend = 0; pend_data = 8'h00;
  endtask

  task automatic drive(input logic dm, clr, as, ag, us, ug, input logic [7:0] aw, uw,
                       output logic [35:0] obs, output logic [35:0] exp);
    int occ;
    bit ls_a, lg_a, ls_u, lg_u, el_a, el_u, wu_raw, wu, wa, g_store, g_get;
    bit e_ovf, e_unf, e_av, e_uv;
    logic [5:0] e_addr;
    logic [7:0] e_wdata, e_rd;
    @(negedge clk);
    d_mode = dm; clear = clr;
    ahb_store_req = as; ahb_get_req = ag; usb_store_req = us; usb_get_req = ug;
    ahb_wdata = aw; usb_wdata = uw;
    #1;
    occ  = exp_q.size();
    ls_a = !dm && as; lg_a = dm && ag; ls_u = dm && us; lg_u = !dm && ug;
    el_a = (ls_a && occ < 64) || (lg_a && occ > 0);
    el_u = (ls_u && occ < 64) || (lg_u && occ > 0);
`ifdef USB_PRIORITY_EN
    wu_raw = el_u;
`else
    wu_raw = el_u && (!el_a || !last_usb);
`endif
    wu = !clr && wu_raw;
    wa = !clr && el_a && !wu_raw;
    g_store = (wa && ls_a) || (wu && ls_u);
    g_get   = (wa && lg_a) || (wu && lg_u);
    e_addr  = (wa || wu) ? (g_store ? 6'(wcnt) : 6'(rcnt)) : 6'd0;
    e_wdata = g_store ? (wa ? aw : uw) : 8'h00;
    e_ovf   = !clr && (ls_a || ls_u) && occ == 64;
    e_unf   = !clr && (lg_a || lg_u) && occ == 0;
    e_av    = !clr && pend == 1;
    e_uv    = !clr && pend == 2;
    e_rd    = (e_av || e_uv) ? pend_data : 8'h00;
    exp = {wa, wu, g_store, e_addr, e_wdata, e_ovf, e_unf, e_av, e_uv, e_rd, 7'(occ)};
    obs = {ahb_grant, usb_grant, mem_we, (ahb_grant || usb_grant) ? mem_addr : 6'd0,
           mem_we ? mem_wdata : 8'h00, overflow_err, underflow_err,
           ahb_rdata_valid, usb_rdata_valid,
           (ahb_rdata_valid || usb_rdata_valid) ? rdata : 8'h00, buffer_occupancy};
    if (clr) begin
      model_reset();
    end else begin
      pend = 0;
      if (g_store) begin
        exp_q.push_back(e_wdata);
        wcnt = (wcnt + 1) % 64;
      end
      if (g_get) begin
        pend_data = exp_q.pop_front();
        pend = wa ? 1 : 2;
        rcnt = (rcnt + 1) % 64;
      end
      if (wa || wu) last_usb = wu;
    end
  endtask

  task automatic test_reset();
    logic [27:0] z;
    n_rst = 1'b0; d_mode = 1'b0; clear = 1'b0;
    ahb_store_req = 1'b1; ahb_get_req = 1'b0; usb_store_req = 1'b0; usb_get_req = 1'b1;
    ahb_wdata = 8'hA5; usb_wdata = 8'h5A;
    repeat (2) @(negedge clk);
    #1;
    z = {ahb_grant, usb_grant, ahb_rdata_valid, usb_rdata_valid, mem_we, mem_addr,
         mem_wdata, buffer_occupancy, overflow_err, underflow_err};
    n_cmp++;
    if (z !== 28'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", z);
    end
    ahb_store_req = 1'b0; usb_get_req = 1'b0;
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [35:0] obs, exp;
    drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 1, 0, 0, 0, 8'(i), 8'hFF, obs, exp);
      n_cmp++;
      if (obs !== exp || obs[32:27] !== 6'(i)) begin
        n_fail++; $display("FAIL fill[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    drive(0, 0, 1, 0, 0, 0, 8'h77, 8'h00, obs, exp);
    n_cmp++;
    if (obs !== exp || obs[18] !== 1'b1 || obs[35] !== 1'b0 || obs[6:0] !== 7'd64) begin
      n_fail++; $display("FAIL fill_overflow: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_drain();
    logic [35:0] obs, exp;
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, obs, exp);
      n_cmp++;
      if (obs !== exp || (i > 0 && (obs[15] !== 1'b1 || obs[14:7] !== 8'(i - 1)))) begin
        n_fail++; $display("FAIL drain[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, obs, exp);
    n_cmp++;
    if (obs !== exp || obs[17] !== 1'b1 || obs[34] !== 1'b0 || obs[14:7] !== 8'h3F
        || obs[6:0] !== 7'd0) begin
      n_fail++; $display("FAIL drain_underflow: got %h expected %h", obs, exp);
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL drain_idle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_wrap();
    logic [35:0] obs, exp;
    drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    for (int k = 0; k < 120; k++) begin
      if (k < 40 || k >= 80) drive(0, 0, 1, 0, 0, 0, 8'($urandom), 8'h00, obs, exp);
      else                   drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, obs, exp);
      n_cmp++;
      if (obs !== exp || (k == 104 && obs[32:27] !== 6'd0) || (k == 80 && obs[32:27] !== 6'd40)) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", k, obs, exp);
      end
    end
    for (int k = 0; k < 41; k++) begin
      drive(0, 0, 0, 0, 0, k < 40, 8'h00, 8'h00, obs, exp);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL wrap_read[%0d]: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [35:0] obs, exp;
    logic [3:0]  ug_seq, want;
`ifdef USB_PRIORITY_EN
    want = 4'b1111;
`else
    want = 4'b1010;
`endif
    drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0, 0, 8'(8'h10 + i), 8'h00, obs, exp);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 1, 0, 8'h00, 8'(8'hC0 + i), obs, exp);
      ug_seq[3 - i] = obs[34];
      n_cmp++;
      if (obs !== exp || obs[35] === obs[34]) begin
        n_fail++; $display("FAIL conflict[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    n_cmp++;
    if (ug_seq !== want) begin
      n_fail++; $display("FAIL conflict_order: got usb grants %b expected %b", ug_seq, want);
    end
  endtask

  task automatic test_clear();
    logic [35:0] obs, exp;
    drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 8'(8'h30 + i), 8'h00, obs, exp);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, obs, exp);
    drive(0, 1, 1, 0, 0, 1, 8'h99, 8'h00, obs, exp);
    n_cmp++;
    if (obs !== exp || obs[15] !== 1'b0 || obs[35] !== 1'b0 || obs[33] !== 1'b0) begin
      n_fail++; $display("FAIL clear_suppress: got %h expected %h", obs, exp);
    end
    drive(0, 0, 1, 0, 0, 0, 8'h42, 8'h00, obs, exp);
    n_cmp++;
    if (obs !== exp || obs[6:0] !== 7'd0 || obs[35] !== 1'b1 || obs[32:27] !== 6'd0) begin
      n_fail++; $display("FAIL clear_restart: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] obs, exp;
    logic [27:0] z;
    drive(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, obs, exp);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0, 0, 8'($urandom), 8'h00, obs, exp);
    drive(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, obs, exp);
    @(posedge clk);
    #2;
    ahb_store_req = 1'b1;
    n_rst = 1'b0;
    #1;
    z = {ahb_grant, usb_grant, ahb_rdata_valid, usb_rdata_valid, mem_we, mem_addr,
         mem_wdata, buffer_occupancy, overflow_err, underflow_err};
    n_cmp++;
    if (z !== 28'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0", z);
    end
    ahb_store_req = 1'b0; usb_get_req = 1'b0;
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 8'(8'hE0 + i), 8'h00, obs, exp);
      n_cmp++;
      if (obs !== exp || obs[32:27] !== 6'(i) || obs[6:0] !== 7'(i)) begin
        n_fail++; $display("FAIL reset_mid_restart[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] obs, exp;
    logic dm;
    dm = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(63) == 0) dm = ~dm;
      drive(dm, $urandom_range(99) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), obs, exp);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_conflict();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_access_arbiter.md
# buffer_access_arbiter

Shares the single-port 64-byte endpoint data buffer between the AHB-Lite slave side and the USB side (RX decoder stores, TX encoder gets). It grants at most one memory access per cycle and owns the circular read/write pointers and the occupancy count. That count is the `Buffer_Occupancy` consumed by the protocol controller. The block sits between both requester sides and the buffer RAM; `d_mode` and `clear` come from the protocol controller.

## Interface
Parameters:
- `DEPTH`, 64, buffer entries (power of two)
- `AW`, 6, address width, log2(DEPTH)

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous, active-low reset
- `d_mode`  in  1  1 = host-to-endpoint (USB stores, AHB gets); 0 = endpoint-to-host (AHB stores, USB gets)
- `clear`  in  1  synchronous buffer flush
- `ahb_store_req`, `ahb_get_req`  in  1 each  AHB-side requests, level-held until granted
- `ahb_wdata`  in  8  AHB store data
- `usb_store_req`, `usb_get_req`  in  1 each  USB-side requests, level-held until granted
- `usb_wdata`  in  8  RX store data
- `ahb_grant`, `usb_grant`  out  1 each  access granted this cycle
- `ahb_rdata_valid`, `usb_rdata_valid`  out  1 each  `rdata` valid for that side
- `rdata`  out  8  read data, equal to `mem_rdata`
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  8  RAM write data
- `mem_rdata`  in  8  RAM read data (synchronous RAM, 1-cycle latency)
- `buffer_occupancy`  out  7  entries held, 0..64
- `overflow_err`, `underflow_err`  out  1 each  blocked-request flags

## Operation
- **Legal requests per mode.**
  - `d_mode`=1: only `usb_store_req` and `ahb_get_req` are legal.
  - `d_mode`=0: only `ahb_store_req` and `usb_get_req` are legal.
  - An illegal request is ignored: no grant and no flag.
- **Eligibility.**
  - A legal store is eligible when occupancy < DEPTH.
  - A legal get is eligible when occupancy > 0.
- **Arbitration.** Between the two eligible sides, round-robin on a `last_winner` register: the side that did not win last is granted. If only one side is eligible, it wins.
- **Store grant.**
  - `mem_we`=1, `mem_addr`=`wr_ptr`, `mem_wdata` = the winner's wdata.
  - `wr_ptr` increments; occupancy increments.
- **Get grant.**
  - `mem_we`=0, `mem_addr`=`rd_ptr`.
  - `rd_ptr` increments; occupancy decrements.
- **Pointer wrap.** Pointers are AW bits and wrap 63→0 naturally. Occupancy is tracked separately at 7 bits, so a full buffer (64) is distinct from an empty one.
- **Flags.**
  - `overflow_err` is high in any cycle where a legal store is pending while occupancy = DEPTH.
  - `underflow_err` is high in any cycle where a legal get is pending while occupancy = 0.
  - The blocked request is not dropped; it stays pending until it becomes eligible.
- **`clear`.**
  - Overrides everything: no grants, `mem_we`=0.
  - Pointers, occupancy and `last_winner` reset at the next edge.
  - Any `rdata_valid` due in the following cycle is suppressed.
- **`d_mode` change.** A change takes effect on the same cycle's legality check. Occupancy is not altered; the protocol controller is responsible for asserting `clear`.

## Timing
- Grants and `mem_*` outputs are combinational from the requests and registered state in the same cycle N.
- A store is written at the end of N.
- `buffer_occupancy` reflects the access from cycle N+1.
- For a get granted in N, the read data and the matching `*_rdata_valid` appear in N+1, as single-cycle pulses.
- One access per cycle, so back-to-back grants to the same side give 1 byte/cycle.
- **Reset values.**
  - All outputs are 0.
  - `wr_ptr` = `rd_ptr` = 0, occupancy = 0.
  - `last_winner` = AHB, so USB wins the first conflict.
- **Reset mid-transfer.** Reset takes effect immediately. A pending `rdata_valid` is lost.

## Configuration
- Macro: `USB_PRIORITY_EN`.
- Defined: the USB side always wins a conflict (fixed priority, for USB bit-timing). `last_winner` is not implemented.
- Undefined: round-robin as described above.
- Legality, flags and timing are identical in both builds.

## Structure
- Package `usb_buffer_pkg`:
  - `BUF_DEPTH`, `BUF_AW` constants
  - `requester_t` enum {REQ_AHB, REQ_USB}
  - `access_t` enum {ACC_NONE, ACC_STORE, ACC_GET}
- Sub-module `buffer_pointer_tracker`:
  - holds `wr_ptr`, `rd_ptr` and occupancy
  - inputs: store/get strobes and `clear`
  - outputs: pointers, occupancy, full, empty
- The arbitration logic stays in the top module.

## Test plan
- **Mode 0 fill.** `d_mode`=0, AHB stores 0x00..0x3F on consecutive cycles → 64 grants; `mem_addr` 0..63; occupancy reaches 64; a 65th store holds `overflow_err`=1 with no grant.
- **Mode 0 drain.** Continuing, USB gets 64 times → `usb_rdata_valid` pulses with 0x00..0x3F in order, one cycle after each grant; occupancy returns to 0; a further get raises `underflow_err`.
- **Wrap-around.** Store 40, get 40, store 40 → write addresses 40..63 then 0..15; reads return the correct data across the wrap.
- **Conflict.** `d_mode`=1, occupancy 10, `usb_store_req` and `ahb_get_req` held together for 4 cycles:
  - round-robin build → grants USB, AHB, USB, AHB
  - `USB_PRIORITY_EN` build → USB on all 4 cycles
- **Clear.** Assert `clear` in the cycle after a get grant → no `rdata_valid`; occupancy = 0 next cycle; the next store goes to address 0.
- **Reset mid-transfer.** Deassert `n_rst` mid-fill → outputs go to 0 immediately; after release, the first store is at address 0.
